// File: rtl/writeback_arbiter_pkg.sv
// Shared types and default widths for the writeback arbiter.
// Used by writeback_arbiter and wb_fifo.
package writeback_arbiter_pkg;

   localparam int WB_ADDRESS_WIDTH = 5;
   localparam int WB_DATA_WIDTH    = 32;

   typedef struct packed {
      logic [WB_ADDRESS_WIDTH-1:0] rd;
      logic [WB_DATA_WIDTH-1:0]    wd;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for long-latency writeback results.
// Power-of-two depth; pointers wrap naturally.
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_req_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  T                             din,
   output T                             head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   T             mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

   // Storage needs no reset: only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter with pending-register scoreboard.
// Define WB_BYPASS_EN for a zero-latency path when the buffer is idle.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = WB_DATA_WIDTH,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               pipe_we,
   input  logic [ADDRESS_WIDTH-1:0]           pipe_rd,
   input  logic [DATA_WIDTH-1:0]              pipe_wd,
   input  logic                               ll_issue,
   input  logic [ADDRESS_WIDTH-1:0]           ll_issue_rd,
   input  logic                               ll_valid,
   input  logic [ADDRESS_WIDTH-1:0]           ll_rd,
   input  logic [DATA_WIDTH-1:0]              ll_wd,
   output logic                               ll_ready,
   input  logic [ADDRESS_WIDTH-1:0]           rs1,
   input  logic [ADDRESS_WIDTH-1:0]           rs2,
   output logic                               hazard,
   output logic                               WE3,
   output logic [ADDRESS_WIDTH-1:0]           A3,
   output logic [DATA_WIDTH-1:0]              WD3,
   output logic [2**ADDRESS_WIDTH-1:0]        pending,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int NREG = 2**ADDRESS_WIDTH;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    wd;
   } req_t;

   req_t            ll_req;
   req_t            head;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            byp;
   logic            sel;
   logic            commit;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] pending_nxt;

   assign ll_req = '{rd: ll_rd, wd: ll_wd};

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (ll_req),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign ll_ready = !rst && !full;

`ifdef WB_BYPASS_EN
   // Only when nothing is buffered, so results can never overtake the FIFO.
   assign byp = !rst && empty && !pipe_we && ll_valid;
`else
   assign byp = 1'b0;
`endif

   assign push = ll_valid && ll_ready && !byp;
   assign pop  = !rst && !empty && !pipe_we;

   always_comb begin
      sel    = 1'b0;
      commit = 1'b0;
      A3     = '0;
      WD3    = '0;
      if (rst) begin
         sel = 1'b0;
      end else if (pipe_we) begin
         sel = 1'b1;
         A3  = pipe_rd;
         WD3 = pipe_wd;
      end else if (pop) begin
         sel    = 1'b1;
         commit = 1'b1;
         A3     = head.rd;
         WD3    = head.wd;
      end else if (byp) begin
         sel    = 1'b1;
         commit = 1'b1;
         A3     = ll_rd;
         WD3    = ll_wd;
      end
      WE3 = sel && (A3 != '0);
   end

   // Set is applied after clear so a same-cycle issue wins.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (ll_issue) set_mask[ll_issue_rd] = 1'b1;
      if (commit)   clr_mask[A3]          = 1'b1;
      pending_nxt    = (pending & ~clr_mask) | set_mask;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

   assign hazard = !rst &&
                   (((rs1 != '0) && pending[rs1]) ||
                    ((rs2 != '0) && pending[rs2]));

endmodule
